// File: rtl/nibble_piso_pkg.sv
// Shared types and default sizing for the nibble parallel-in/serial-out unloader.
package nibble_piso_pkg;
   localparam int WIDTH_DEF = 4;
   localparam int DEPTH_DEF = 16;
   localparam int IDX_W     = $clog2(DEPTH_DEF);

   typedef logic [3:0] nibble_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;
endpackage

// File: rtl/nibble_piso_16_reg_en.sv
// WIDTH-bit storage register with synchronous active-high reset and load enable.
module nibble_reg_en #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)       q <= '0;
      else if (load) q <= d;
   end
endmodule

// File: rtl/nibble_piso_16.sv
// Parallel-in/serial-out nibble unloader with valid/ready on both sides and a global enable.
// Build option: define NIBBLE_PISO_MSB_FIRST_EN to emit entry DEPTH-1 first.
//
// state | meaning
// IDLE  | buffer empty, waiting for an array load; Q=0, out_valid=0
// SHIFT | presenting buffer entry selected by idx on Q until its beat is taken
module nibble_piso_16
   import nibble_piso_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         D [DEPTH-1:0],
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         Q,
   output logic                     last,
   output logic [$clog2(DEPTH)-1:0] idx
);
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   piso_state_t    state, state_nxt;
   logic [IW-1:0]  idx_nxt;
   logic [IW-1:0]  sel;
   logic           load, beat, at_last;
   logic [WIDTH-1:0] buffer [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_buf
      nibble_reg_en #(.WIDTH(WIDTH)) u_reg (
         .clk  (clk),
         .rst  (rst),
         .load (load),
         .d    (D[g]),
         .q    (buffer[g])
      );
   end

`ifdef NIBBLE_PISO_MSB_FIRST_EN
   assign sel = LAST_IDX - idx;
`else
   assign sel = idx;
`endif

   assign at_last = (idx == LAST_IDX);
   assign load    = in_valid & in_ready;
   assign beat    = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      Q         = '0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = en;
            if (load) begin
               state_nxt = SHIFT;
               idx_nxt   = '0;
            end
         end
         SHIFT: begin
            out_valid = en;
            Q         = buffer[sel];
            last      = at_last;
            // Accepting the next array on the final beat avoids an idle bubble.
            in_ready  = en & at_last & out_ready;
            if (beat) begin
               if (at_last) begin
                  idx_nxt   = '0;
                  state_nxt = load ? SHIFT : IDLE;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_nibble_piso_16.sv
// Self-checking bench for nibble_piso_16 against a queue-based stream model.
module tb_nibble_piso_16;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       r_rst, r_en, r_in_valid, r_out_ready;
   logic [3:0] r_d [DEPTH-1:0];
   logic       in_ready, out_valid, last;
   logic [3:0] q;
   logic [3:0] idx;

   int checks = 0;
   int errors = 0;
   logic [3:0] mq [$];

   nibble_piso_16 dut (
      .clk       (clk),
      .rst       (r_rst),
      .en        (r_en),
      .in_valid  (r_in_valid),
      .in_ready  (in_ready),
      .D         (r_d),
      .out_valid (out_valid),
      .out_ready (r_out_ready),
      .Q         (q),
      .last      (last),
      .idx       (idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_idx();
      return (mq.size() > 0) ? DEPTH - mq.size() : 0;
   endfunction

   // Called just after a falling edge with inputs already driven; checks, then advances model.
   task automatic step();
      int  n;
      bit  act, e_ov, e_ir, e_last;
      int  e_q;
      #1;
      n      = mq.size();
      act    = (n > 0);
      e_ov   = r_en && act;
      e_q    = act ? int'(mq[0]) : 0;
      e_last = act && (n == 1);
      e_ir   = r_en && (!act || (n == 1 && r_out_ready));
      check("out_valid", int'(out_valid), int'(e_ov));
      check("in_ready",  int'(in_ready),  int'(e_ir));
      check("q",         int'(q),         e_q);
      check("idx",       int'(idx),       model_idx());
      check("last",      int'(last),      int'(e_last));
      if (r_rst) begin
         mq.delete();
      end else if (r_en) begin
         if (e_ov && r_out_ready) void'(mq.pop_front());
         if (r_in_valid && e_ir) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef NIBBLE_PISO_MSB_FIRST_EN
               mq.push_back(r_d[DEPTH-1-i]);
`else
               mq.push_back(r_d[i]);
`endif
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic load_random();
      for (int i = 0; i < DEPTH; i++) r_d[i] = 4'($urandom_range(0, 15));
      r_in_valid = 1'b1;
      step();
      r_in_valid = 1'b0;
   endtask

   initial begin
      r_rst = 1'b1; r_en = 1'b1; r_in_valid = 1'b0; r_out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) r_d[i] = '0;
      repeat (2) @(negedge clk);
      step();
      r_rst = 1'b0;

      // Ascending array streamed with out_ready held high.
      for (int i = 0; i < DEPTH; i++) r_d[i] = 4'(i);
      r_in_valid = 1'b1; r_out_ready = 1'b1;
      step();
      r_in_valid = 1'b0;
      repeat (18) step();

      // Backpressure with descending data.
      for (int i = 0; i < DEPTH; i++) r_d[i] = 4'(15 - i);
      r_in_valid = 1'b1;
      step();
      r_in_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         r_out_ready = (k % 3 == 0);
         step();
      end

      // Back-to-back arrays: second load offered on the final beat.
      r_out_ready = 1'b1;
      load_random();
      for (int k = 0; k < 20; k++) begin
         r_in_valid = (mq.size() == 1);
         if (r_in_valid) for (int i = 0; i < DEPTH; i++) r_d[i] = 4'hA;
         step();
      end
      r_in_valid = 1'b0;
      repeat (18) step();

      // Enable gap of three cycles at idx 5.
      load_random();
      for (int k = 0; k < 20 && model_idx() != 5; k++) step();
      r_en = 1'b0;
      repeat (3) step();
      r_en = 1'b1;
      repeat (14) step();

      // Reset mid-stream at idx 9 with a concurrent load offer.
      load_random();
      for (int k = 0; k < 20 && model_idx() != 9; k++) step();
      r_rst = 1'b1; r_in_valid = 1'b1;
      step();
      r_rst = 1'b0; r_in_valid = 1'b0;
      repeat (3) step();

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         r_rst       = ($urandom_range(0, 99) == 0);
         r_en        = ($urandom_range(0, 9) != 0);
         r_in_valid  = ($urandom_range(0, 3) != 0);
         r_out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < DEPTH; i++) r_d[i] = 4'($urandom_range(0, 15));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nibble_piso_16.md
Name: nibble_piso_16

Overview:
- Parallel-in/serial-out nibble unloader: the reader end of the 16-stage nibble shift chain.
- Accepts one 16-entry array of 4-bit words in a single handshake and streams it out one nibble per accepted beat.
- Uses valid/ready on both sides, with a global enable.
- Sits between the parallel nibble store and any serial nibble consumer (display scanner, UART nibble packer).

Parameters:
- WIDTH, 4, bits per entry.
- DEPTH, 16, entries per load; must be >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, all state holds and no handshake completes.
- in_valid  input  1  upstream presents a full array on D.
- in_ready  output  1  block can accept a load this cycle.
- D  input  [WIDTH-1:0] x [DEPTH-1:0]  unpacked parallel data array.
- out_valid  output  1  Q holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- Q  output  WIDTH  current serial nibble.
- last  output  1  high with the final beat of an array.
- idx  output  $clog2(DEPTH)  index of the beat currently on Q.

Behaviour:
- Reset values (rst sampled high at clk edge; has priority over en and all handshakes):
  - state=IDLE, buffer=all zero, idx=0, out_valid=0, Q=0, last=0.
  - in_ready=1 if en=1, else 0.
  - Reset mid-stream discards the remaining beats; no partial beat is emitted afterwards.
- Transfers:
  - Load: in_valid & in_ready & en.
  - Beat: out_valid & out_ready & en.
- States:
  - IDLE: in_ready=en; out_valid=0; Q=0.
    - On load, capture all DEPTH entries, set idx=0, go to SHIFT.
    - First beat is visible the following cycle (1-cycle load-to-out latency).
  - SHIFT: out_valid=en; Q=buffer[idx]; last=(idx==DEPTH-1).
    - Beat with idx<DEPTH-1: idx increments.
    - Beat with idx==DEPTH-1: return to IDLE; idx=0.
    - No beat: Q, idx and last hold stable (AXI-style: data must not change while valid and not ready).
- Back-to-back loads:
  - in_ready = en & (IDLE | (SHIFT & idx==DEPTH-1 & out_ready)).
  - This is a combinational path from out_ready to in_ready.
  - A load coincident with the last beat stays in SHIFT with the new buffer, idx=0, so there is no bubble between arrays.
- en=0: in_ready=0 and out_valid=0 combinationally; buffer, idx and state frozen. Output resumes unchanged when en returns.
- D is sampled only on a load; changes on D at other times are ignored.
- idx wraps only via the return to IDLE or a reload, never by overflow.
- Throughput: DEPTH beats per DEPTH cycles when out_ready is held high and loads are back-to-back.

Optional Feature:
- Macro: NIBBLE_PISO_MSB_FIRST_EN.
- Defined: beat order is reversed, so Q = buffer[DEPTH-1-idx] (entry DEPTH-1 first, entry 0 last). idx still counts 0..DEPTH-1, and last still asserts on idx==DEPTH-1.
- Undefined: entry 0 is emitted first.

Decomposition:
- Package nibble_piso_pkg:
  - Default WIDTH/DEPTH localparams.
  - nibble_t typedef (logic [3:0]).
  - State enum piso_state_t {IDLE, SHIFT}.
  - IDX_W = $clog2(DEPTH).
- Sub-module nibble_reg_en: WIDTH-bit register with sync reset and load enable, instantiated DEPTH times in a generate loop for the buffer.
- FSM, counter and handshake logic live in the top module.

Test Plan:
- Reset then load: load D[i]=i (0..15), out_ready=1.
  - Q=0,1,...,15 on 16 consecutive cycles starting 1 cycle after the load.
  - last high only with Q=15; then out_valid=0 and in_ready=1.
- Backpressure: load D[i]=15-i, toggle out_ready 1,0,0,1,...
  - Q holds stable while out_ready=0.
  - Sequence is 15..0 with no beat lost or duplicated.
- Back-to-back: second array D[i]=4'hA present with in_valid at the cycle of beat 15.
  - in_ready=1 that cycle; next cycle Q=4'hA, idx=0, no idle gap.
- Enable gating: deassert en for 3 cycles at idx=5.
  - out_valid=0, in_ready=0 during the gap; on re-enable Q=buffer[5], idx=5.
- Reset mid-stream: rst at idx=9 with in_valid=1.
  - Next cycle out_valid=0, Q=0, idx=0, IDLE; the concurrent load is ignored.
- MSB-first build (NIBBLE_PISO_MSB_FIRST_EN): load D[i]=i.
  - Q=15,14,...,0; last high with Q=0.
